// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package inst_fetch_queue_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_INC = 4;

    typedef enum logic {
        FS_FETCH = 1'b0,
        FS_DRAIN = 1'b1
    } fetchState_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] pcPlus4;
    } fetchEntry_t;

    // Sequential successor address; wraps modulo 2^32.
    function automatic logic [INST_W-1:0] pcNext(input logic [INST_W-1:0] pc);
        return pc + INST_W'(PC_INC);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous FIFO of fetched entries; flush clears it and wins over push.
module inst_fetch_queue_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetchEntry_t                pushData,
    input  logic                       pop,
    output fetchEntry_t                popData,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetchEntry_t      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             doPush;
    logic             doPop;
    logic             notEmpty;

    assign notEmpty = (count != '0);
    assign doPop    = pop && notEmpty;
    assign doPush   = push && ((count != CNT_W'(DEPTH)) || doPop);

    // Pointer and count update; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doPush) tail <= tail + PTR_W'(1);
            if (doPop)  head <= head + PTR_W'(1);
            if (doPush && !doPop)
                count <= count + CNT_W'(1);
            else if (!doPush && doPop)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[tail] <= pushData;
    end

    // Head reads as zero while empty so decode never sees stale words.
    assign popData = notEmpty ? mem[head] : '0;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: sequential address generation, single-outstanding imem
// handshake, redirect/drain control and the decode-facing queue.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst_data,
    output logic [31:0]                inst_pc,
    output logic [31:0]                inst_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetchState_t       state;
    fetchState_t       stateNext;
    logic [INST_W-1:0] fetchPc;
    logic [INST_W-1:0] fetchPcNext;
    logic [INST_W-1:0] targetPc;
    logic [INST_W-1:0] targetPcNext;
    logic [INST_W-1:0] redirAligned;
    logic              reqLive;
    logic              pushEn;
    logic              popEn;
    fetchEntry_t       pushEntry;
    fetchEntry_t       headEntry;

    assign redirAligned = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FS_FETCH;
            fetchPc  <= RESET_PC;
            targetPc <= RESET_PC;
        end else begin
            state    <= stateNext;
            fetchPc  <= fetchPcNext;
            targetPc <= targetPcNext;
        end
    end

    // fetchPc is always the address on the bus; targetPc parks a redirect during DRAIN.
    always_comb begin
        stateNext    = state;
        fetchPcNext  = fetchPc;
        targetPcNext = targetPc;
        reqLive      = 1'b0;
        pushEn       = 1'b0;
        case (state)
            FS_FETCH: begin
                reqLive = (occupancy < CNT_W'(DEPTH));
                if (redirect_valid) begin
                    if (reqLive && !imem_ack) begin
                        stateNext    = FS_DRAIN;
                        targetPcNext = redirAligned;
                    end else begin
                        fetchPcNext = redirAligned;
                    end
                end else if (reqLive && imem_ack) begin
                    pushEn      = 1'b1;
                    fetchPcNext = pcNext(fetchPc);
                end
            end
            FS_DRAIN: begin
                reqLive = 1'b1;
                if (redirect_valid) targetPcNext = redirAligned;
                if (imem_ack) begin
                    stateNext   = FS_FETCH;
                    fetchPcNext = redirect_valid ? redirAligned : targetPc;
                end
            end
            default: stateNext = FS_FETCH;
        endcase
    end

    assign imem_req  = reqLive && !reset;
    assign imem_addr = fetchPc;

    assign pushEntry = '{inst: imem_rdata, pc: fetchPc, pcPlus4: pcNext(fetchPc)};
    assign popEn     = inst_valid && inst_ready;

    inst_fetch_queue_fifo #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect_valid),
        .push    (pushEn),
        .pushData(pushEntry),
        .pop     (popEn),
        .popData (headEntry),
        .count   (occupancy)
    );

    assign inst_valid    = (occupancy != '0);
    assign inst_data     = headEntry.inst;
    assign inst_pc       = headEntry.pc;
    assign inst_pc_plus4 = headEntry.pcPlus4;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: latency-configurable memory model plus a
// scoreboard of expected PCs compared at every decode handshake.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic [2:0]  occupancy;

    int          checks = 0;
    int          errors = 0;
    int          memLat = 0;
    int          waitCnt = 0;
    logic [31:0] expPc[$];

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_pc_plus4 (inst_pc_plus4),
        .occupancy     (occupancy)
    );

    // Memory: ack after memLat extra cycles of a held request.
    assign imem_ack   = imem_req && (waitCnt >= memLat);
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    always_ff @(posedge clk) begin
        if (!imem_req || imem_ack) waitCnt <= 0;
        else                       waitCnt <= waitCnt + 1;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted head must match the next expected PC.
    initial begin
        logic [31:0] p;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
                if (expPc.size() == 0) begin
                    checkVal("sb_unexpected_pop", 32'(expPc.size()), 32'd1);
                end else begin
                    p = expPc.pop_front();
                    checkVal("pop_pc", inst_pc, p);
                    checkVal("pop_pc_plus4", inst_pc_plus4, p + 32'd4);
                    checkVal("pop_data", inst_data, p ^ 32'hA5A5_0000);
                end
            end
        end
    end

    task automatic applyReset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b0;
        @(negedge clk);
        checkVal("rst_req_drop", 32'(imem_req), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkVal("rst_req", 32'(imem_req), 32'd0);
        checkVal("rst_valid", 32'(inst_valid), 32'd0);
        checkVal("rst_occ", 32'(occupancy), 32'd0);
        checkVal("rst_addr", imem_addr, RESET_PC);
        checkVal("rst_data", inst_data, 32'd0);
        checkVal("rst_pc", inst_pc, 32'd0);
        checkVal("rst_pc4", inst_pc_plus4, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expPc.delete();
        @(negedge clk);
        checkVal("first_req", 32'(imem_req), 32'd1);
        checkVal("first_addr", imem_addr, RESET_PC);
    endtask

    task automatic waitReq(input logic [31:0] addr, input string tag);
        int c = 0;
        while (c < 100 && !(imem_req === 1'b1 && imem_addr === addr)) begin
            @(negedge clk);
            c++;
        end
        checkVal({tag, "_req"}, 32'(imem_req), 32'd1);
        checkVal({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic waitSbEmpty(input string tag);
        int c = 0;
        while (c < 200 && expPc.size() != 0) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkVal({tag, "_sb_left"}, 32'(expPc.size()), 32'd0);
    endtask

    initial begin
        // 1: combinational memory, decode always ready
        memLat = 0;
        applyReset();
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) expPc.push_back(32'(i * 4));
        waitSbEmpty("s1");
        inst_ready = 1'b0;

        // 2: decode stalled, queue fills, one pop re-arms the request
        applyReset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkVal("s2_occ_full", 32'(occupancy), 32'd4);
        checkVal("s2_req_low", 32'(imem_req), 32'd0);
        checkVal("s2_addr_hold", imem_addr, 32'd16);
        repeat (2) @(negedge clk);
        checkVal("s2_still_full", 32'(occupancy), 32'd4);
        checkVal("s2_still_low", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        expPc.push_back(32'd0);
        inst_ready = 1'b1;
        @(negedge clk);
        checkVal("s2_req_pop_cycle", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        @(negedge clk);
        checkVal("s2_req_rise", 32'(imem_req), 32'd1);
        checkVal("s2_req_addr", imem_addr, 32'd16);
        checkVal("s2_occ3", 32'(occupancy), 32'd3);
        checkVal("s2_head", inst_pc, 32'd4);
        checkVal("s2_sb_left", 32'(expPc.size()), 32'd0);

        // 3: slow memory, redirect while read at 8 is pending
        memLat = 2;
        applyReset();
        inst_ready = 1'b1;
        expPc.push_back(32'h0);
        expPc.push_back(32'h4);
        expPc.push_back(32'h100);
        expPc.push_back(32'h104);
        waitReq(32'd8, "s3_pend");
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checkVal("s3_drain_req", 32'(imem_req), 32'd1);
        checkVal("s3_drain_addr", imem_addr, 32'd8);
        checkVal("s3_drain_occ", 32'(occupancy), 32'd0);
        waitReq(32'h100, "s3_new");
        waitSbEmpty("s3");
        inst_ready = 1'b0;

        // 4: redirect coincident with ack of 12, two queued, pop same cycle
        memLat = 1;
        applyReset();
        expPc.push_back(32'h0);
        expPc.push_back(32'h4);
        expPc.push_back(32'h200);
        expPc.push_back(32'h204);
        waitReq(32'd8, "s4_pend");
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        @(negedge clk);
        checkVal("s4_occ2", 32'(occupancy), 32'd2);
        checkVal("s4_addr12", imem_addr, 32'd12);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        checkVal("s4_ack_same", 32'(imem_ack), 32'd1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checkVal("s4_new_req", 32'(imem_req), 32'd1);
        checkVal("s4_new_addr", imem_addr, 32'h200);
        checkVal("s4_flush_occ", 32'(occupancy), 32'd0);
        checkVal("s4_flush_valid", 32'(inst_valid), 32'd0);
        waitSbEmpty("s4");
        inst_ready = 1'b0;

        // 5: address wrap at the top of the address space
        memLat = 0;
        applyReset();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        expPc.push_back(32'hFFFF_FFF8);
        expPc.push_back(32'hFFFF_FFFC);
        expPc.push_back(32'h0000_0000);
        expPc.push_back(32'h0000_0004);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checkVal("s5_req", 32'(imem_req), 32'd1);
        checkVal("s5_addr", imem_addr, 32'hFFFF_FFF8);
        checkVal("s5_occ", 32'(occupancy), 32'd0);
        waitSbEmpty("s5");
        inst_ready = 1'b0;

        // 6: reset with three queued and a read outstanding
        memLat = 2;
        applyReset();
        for (int c = 0; c < 100 && occupancy != 3'd3; c++) @(negedge clk);
        checkVal("s6_occ3", 32'(occupancy), 32'd3);
        checkVal("s6_pending_req", 32'(imem_req), 32'd1);
        checkVal("s6_pending_addr", imem_addr, 32'd12);
        @(posedge clk);
        #1;
        applyReset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
